// File: rtl/snn_core_engine.sv
// snn_core_engine: two-layer digit classifier core (784 -> 32 -> 10).
// Pixels come from an external RAM via addr_in_unit/q_in. Each neuron does
// a signed MAC, rectifies to 11 bits and maps through an activation LUT.
// Results go to the RHU1 (hidden) and ROU1 (output) RAMs. The arg-max of
// ROU1 is reported on digit, together with done.
// Ports: clk, rst_n (async active-low), start (1-cycle pulse, IDLE only),
//        q_in[7:0] (pixel, 1 cycle after address), addr_in_unit[9:0],
//        digit[3:0], done.
// Config macro: SNN_DONE_HOLD_EN. When defined, done is held high until
// the next accepted start. Otherwise done is a single-cycle pulse.

// Synchronous-read ROM. The write port is only a load path and is tied off
// in this core.
module snn_rom #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] rom [DEPTH];

   always_ff @(posedge clk) begin
      if (we) rom[addr] <= wdata;
      rdata <= rom[addr];
   end
endmodule

// Single-port synchronous-read RAM
module snn_ram #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);
   logic [7:0] ram [DEPTH];

   always_ff @(posedge clk) begin
      if (we) ram[addr] <= wdata;
      rdata <= ram[addr];
   end
endmodule

module snn_core_engine (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] q_in,
   output logic [9:0] addr_in_unit,
   output logic [3:0] digit,
   output logic       done
);
   localparam int unsigned N_IN  = 784;
   localparam int unsigned N_HID = 32;
   localparam int unsigned N_OUT = 10;
   localparam int unsigned ACC_W = 26;

   typedef enum logic [3:0] {
      IDLE, MAC_HID, RECT_HID, WR_HID, MAC_OUT, RECT_OUT, WR_OUT, ARGMAX, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [9:0]         cnt_q, cnt_d;
   logic [9:0]         idx_q, idx_d;
   logic [14:0]        hw_addr_q, hw_addr_d;
   logic [8:0]         ow_addr_q, ow_addr_d;
   logic [4:0]         h_q, h_d;
   logic [3:0]         o_q, o_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [7:0]         best_q, best_d;
   logic [3:0]         best_idx_q, best_idx_d;
   logic [3:0]         digit_q, digit_d;
   logic               done_q, done_d;

   logic [7:0]         rhw_rdata, row_rdata, lut_rdata, rhu_rdata, rou_rdata;
   logic               rhu_we, rou_we;
   logic [4:0]         rhu_addr;
   logic [3:0]         rou_addr;
   logic [7:0]         op_a, op_w;
   logic signed [15:0] a_s, w_s, prod;
   logic [ACC_W-1:0]   acc_sum;
   logic [10:0]        r_c;
   logic [10:0]        lut_addr;
   logic               cand_gt;
   logic [3:0]         win_idx;

   // Memories
   snn_rom #(.DEPTH(N_IN*N_HID), .AW(15)) RHW1 (
      .clk(clk), .we(1'b0), .addr(hw_addr_q), .wdata(8'h00), .rdata(rhw_rdata));
   snn_rom #(.DEPTH(N_HID*N_OUT), .AW(9)) ROW1 (
      .clk(clk), .we(1'b0), .addr(ow_addr_q), .wdata(8'h00), .rdata(row_rdata));
   snn_rom #(.DEPTH(2048), .AW(11)) RAF1 (
      .clk(clk), .we(1'b0), .addr(lut_addr), .wdata(8'h00), .rdata(lut_rdata));
   snn_ram #(.DEPTH(N_HID), .AW(5)) RHU1 (
      .clk(clk), .we(rhu_we), .addr(rhu_addr), .wdata(lut_rdata), .rdata(rhu_rdata));
   snn_ram #(.DEPTH(N_OUT), .AW(4)) ROU1 (
      .clk(clk), .we(rou_we), .addr(rou_addr), .wdata(lut_rdata), .rdata(rou_rdata));

   // Datapath: operand select, signed MAC, rectify, LUT address, arg-max compare
   always_comb begin
      rhu_we   = (state_q == WR_HID);
      rou_we   = (state_q == WR_OUT);
      rhu_addr = rhu_we ? h_q : idx_q[4:0];
      rou_addr = rou_we ? o_q : ((cnt_q < 10'(N_OUT)) ? cnt_q[3:0] : 4'(N_OUT - 1));
      op_a     = (state_q == MAC_HID) ? q_in      : rhu_rdata;
      op_w     = (state_q == MAC_HID) ? rhw_rdata : row_rdata;
      a_s      = 16'(signed'(op_a));
      w_s      = 16'(signed'(op_w));
      prod     = a_s * w_s;
      acc_sum  = acc_q + {{(ACC_W-16){prod[15]}}, prod};
      if (!acc_q[25] && (|acc_q[24:17]))     r_c = 11'h3FF;
      else if (acc_q[25] && !(&acc_q[24:17])) r_c = 11'h400;
      else                                    r_c = acc_q[17:7];
      lut_addr = {~r_c[10], r_c[9:0]};
      cand_gt  = (rou_rdata > best_q);
      win_idx  = cand_gt ? 4'(cnt_q - 10'd1) : best_idx_q;
   end

   // Next-state and control
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      hw_addr_d  = hw_addr_q;
      ow_addr_d  = ow_addr_q;
      h_d        = h_q;
      o_d        = o_q;
      acc_d      = acc_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      digit_d    = digit_q;
`ifdef SNN_DONE_HOLD_EN
      done_d     = done_q;
`else
      done_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = MAC_HID;
               cnt_d     = '0;
               idx_d     = '0;
               hw_addr_d = '0;
               ow_addr_d = '0;
               h_d       = '0;
               o_d       = '0;
               acc_d     = '0;
               done_d    = 1'b0;
            end
         end
         // Addresses advance for N-1 cycles; data lags one cycle, so counts 1..N accumulate
         MAC_HID: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q < 10'(N_IN - 1)) begin
               idx_d     = idx_q + 10'd1;
               hw_addr_d = hw_addr_q + 15'd1;
            end
            if (cnt_q != 10'd0) acc_d = acc_sum;
            if (cnt_q == 10'(N_IN)) state_d = RECT_HID;
         end
         RECT_HID: state_d = WR_HID;
         WR_HID: begin
            acc_d = '0;
            cnt_d = '0;
            idx_d = '0;
            if (h_q == 5'(N_HID - 1)) begin
               state_d = MAC_OUT;
            end else begin
               h_d       = h_q + 5'd1;
               hw_addr_d = hw_addr_q + 15'd1;
               state_d   = MAC_HID;
            end
         end
         MAC_OUT: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q < 10'(N_HID - 1)) begin
               idx_d     = idx_q + 10'd1;
               ow_addr_d = ow_addr_q + 9'd1;
            end
            if (cnt_q != 10'd0) acc_d = acc_sum;
            if (cnt_q == 10'(N_HID)) state_d = RECT_OUT;
         end
         RECT_OUT: state_d = WR_OUT;
         WR_OUT: begin
            acc_d = '0;
            cnt_d = '0;
            idx_d = '0;
            if (o_q == 4'(N_OUT - 1)) begin
               best_d     = '0;
               best_idx_d = '0;
               state_d    = ARGMAX;
            end else begin
               o_d       = o_q + 4'd1;
               ow_addr_d = ow_addr_q + 9'd1;
               state_d   = MAC_OUT;
            end
         end
         // Strict compare keeps the lowest index on ties
         ARGMAX: begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q != 10'd0 && cand_gt) begin
               best_d     = rou_rdata;
               best_idx_d = win_idx;
            end
            if (cnt_q == 10'(N_OUT)) begin
               digit_d = win_idx;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         hw_addr_q  <= '0;
         ow_addr_q  <= '0;
         h_q        <= '0;
         o_q        <= '0;
         acc_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         digit_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         hw_addr_q  <= hw_addr_d;
         ow_addr_q  <= ow_addr_d;
         h_q        <= h_d;
         o_q        <= o_d;
         acc_q      <= acc_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         digit_q    <= digit_d;
         done_q     <= done_d;
      end
   end

   assign addr_in_unit = idx_q;
   assign digit        = digit_q;
   assign done         = done_q;
endmodule

// File: tb/tb_snn_core_engine.sv
// Self-checking bench for snn_core_engine (default build: done is a pulse).
// A reference model computes the expected hidden/output results and digit.
// The expected digit is queued at start and popped when done is seen.
module tb_snn_core_engine;
   localparam int N_IN  = 784;
   localparam int N_HID = 32;
   localparam int N_OUT = 10;
   localparam int T_MAX = 26000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] q_in;
   logic [9:0] addr_in_unit;
   logic [3:0] digit;
   logic       done;

   logic [7:0] img   [N_IN];
   logic [7:0] hw_m  [N_IN*N_HID];
   logic [7:0] ow_m  [N_HID*N_OUT];
   logic [7:0] lut_m [2048];
   logic [7:0] hid_m [N_HID];
   logic [7:0] out_m [N_OUT];
   int         exp_digit;
   int         exp_q [$];
   int         n_checks = 0;
   int         n_pass   = 0;

   snn_core_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in),
      .addr_in_unit(addr_in_unit), .digit(digit), .done(done));

   always #5 clk = ~clk;

   // External input RAM, 1-cycle read latency
   always @(posedge clk)
      q_in <= (addr_in_unit < 10'(N_IN)) ? img[addr_in_unit] : 8'h00;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Saturating rectify, returned as the biased LUT address
   function automatic int lut_index(input int acc);
      int r;
      if (acc >= 131072)      r = 1023;
      else if (acc < -131072) r = -1024;
      else                    r = acc >>> 7;
      return r + 1024;
   endfunction

   // Load DUT memories from the bench copies and compute expected results
   task automatic load_and_model();
      int acc, a, w, best;
      for (int i = 0; i < N_IN*N_HID; i++) dut.RHW1.rom[i] = hw_m[i];
      for (int i = 0; i < N_HID*N_OUT; i++) dut.ROW1.rom[i] = ow_m[i];
      for (int i = 0; i < 2048; i++) dut.RAF1.rom[i] = lut_m[i];
      for (int h = 0; h < N_HID; h++) begin
         acc = 0;
         for (int i = 0; i < N_IN; i++) begin
            a = $signed(img[i]);
            w = $signed(hw_m[h*N_IN + i]);
            acc += a * w;
         end
         hid_m[h] = lut_m[lut_index(acc)];
      end
      for (int o = 0; o < N_OUT; o++) begin
         acc = 0;
         for (int h = 0; h < N_HID; h++) begin
            a = $signed(hid_m[h]);
            w = $signed(ow_m[o*N_HID + h]);
            acc += a * w;
         end
         out_m[o] = lut_m[lut_index(acc)];
      end
      best = 0;
      for (int o = 1; o < N_OUT; o++) if (out_m[o] > out_m[best]) best = o;
      exp_digit = best;
   endtask

   // Scoreboard: every done must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) check("spurious_done", 1, 0);
         else check("digit", int'(digit), exp_q.pop_front());
      end
   end

   // One classification; optionally re-pulse start mid-run
   task automatic run(input bit mid_pulse);
      int cyc;
      exp_q.push_back(exp_digit);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      while (!done && cyc < T_MAX) begin
         start = mid_pulse && (cyc == 1000);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", int'(done), 1);
      check("latency_window", int'(cyc >= 25000 && cyc < T_MAX), 1);
      @(negedge clk);
      check("done_pulse", int'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_digit", int'(digit), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(addr_in_unit), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_addr", int'(addr_in_unit), 0);
      check("idle_done", int'(done), 0);

      // Saturation set: pixels and hidden weights 0x7F, output row 7 = +1
      for (int i = 0; i < N_IN; i++) img[i] = 8'h7F;
      for (int i = 0; i < N_IN*N_HID; i++) hw_m[i] = 8'h7F;
      for (int i = 0; i < N_HID*N_OUT; i++) ow_m[i] = (i / N_HID == 7) ? 8'h01 : 8'h00;
      for (int a = 0; a < 2048; a++) lut_m[a] = 8'(a >> 4);
      load_and_model();

      // Reset mid-run aborts immediately
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (200) @(negedge clk);
      check("run_addr_moving", int'(addr_in_unit != 10'd0), 1);
      rst_n = 1'b0;
      #1;
      check("abort_addr", int'(addr_in_unit), 0);
      check("abort_done", int'(done), 0);
      check("abort_digit", int'(digit), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      run(1'b1);
      check("digit_class7", int'(digit), 7);
      for (int h = 0; h < N_HID; h++)
         check($sformatf("hid_sat[%0d]", h), int'(dut.RHU1.ram[h]), int'(lut_m[11'h7FF]));
      for (int o = 0; o < N_OUT; o++)
         check($sformatf("out[%0d]", o), int'(dut.ROU1.ram[o]), int'(out_m[o]));

      // Same data again must give the same class
      repeat (4) @(negedge clk);
      run(1'b0);
      check("digit_repeat", int'(digit), 7);

      // Mixed-range hidden layer; all output weights 0 forces a tie
      for (int i = 0; i < N_IN; i++) img[i] = 8'($urandom_range(63));
      for (int i = 0; i < N_IN*N_HID; i++) begin
         if (i < N_IN)          hw_m[i] = 8'h80;
         else if (i < 2*N_IN)   hw_m[i] = 8'h7F;
         else                   hw_m[i] = 8'($urandom_range(63)) - 8'd32;
      end
      for (int i = 0; i < N_HID*N_OUT; i++) ow_m[i] = 8'h00;
      for (int a = 0; a < 2048; a++) lut_m[a] = 8'(a * 37 + (a >> 5));
      load_and_model();
      repeat (4) @(negedge clk);
      run(1'b0);
      for (int h = 0; h < N_HID; h++)
         check($sformatf("hid[%0d]", h), int'(dut.RHU1.ram[h]), int'(hid_m[h]));
      repeat (5) @(negedge clk);
      check("digit_tie_hold", int'(digit), 0);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
